// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

  // Bits needed to count 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_sign_adj.sv
// Conditional two's-complement negate. The most-negative input maps to itself,
// which is exactly its unsigned magnitude, so no extra bit is needed.
module mult_sign_adj #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/seq_multiplier.sv
// WIDTH x WIDTH shift-add multiplier, one partial product per clock, with
// valid/ready handshakes on both sides and optional signed operation.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  input  logic                            is_signed,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [prod_width(WIDTH)-1:0]    p,
  output logic                            busy
);

  localparam int unsigned PW = prod_width(WIDTH);
  localparam int unsigned CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic             signed_mode;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [CW-1:0]    count;
  logic [PW-1:0]    p_q;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    prod_raw;
  logic [PW-1:0]    prod_fix;

  // With SIGNED_EN=0 this is constant zero and all sign hardware folds away.
  assign signed_mode = SIGNED_EN & is_signed;

  mult_sign_adj #(.W(WIDTH)) u_a_mag (
    .din  (a),
    .neg  (signed_mode & a[WIDTH-1]),
    .dout (a_mag)
  );

  mult_sign_adj #(.W(WIDTH)) u_b_mag (
    .din  (b),
    .neg  (signed_mode & b[WIDTH-1]),
    .dout (b_mag)
  );

  // Product low bits shift into the vacated top of mplier each iteration.
  assign addend   = mplier[0] ? mcand : '0;
  assign sum      = {1'b0, acc} + {1'b0, addend};
  assign prod_raw = {sum, mplier[WIDTH-1:1]};

  mult_sign_adj #(.W(PW)) u_p_sign (
    .din  (prod_raw),
    .neg  (neg),
    .dout (prod_fix)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign p         = p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)       state_nxt = CALC;
      CALC:    if (count == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // NOTE: the register set is small, so every datapath register is reset too;
  // a mid-operation reset then leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      count  <= '0;
      p_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register sees pre-edge values of the others.
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          count  <= count + CW'(1);
          if (count == LAST) p_q <= prod_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
